// File: rtl/pmf_issue_sched_pkg.sv
// Shared encodings for the pmfALU issue scheduler: sequencer states, ALU op
// codes, and the state entered when an instruction issues.
package pmf_issue_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRIM = 2'd1,
    S_INV  = 2'd2,
    S_MADD = 2'd3
  } sched_state_e;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  // Subtract takes the two-pass path through INV; everything else is single-pass.
  function automatic sched_state_e issue_state(input logic [1:0] op);
    if (op == ALU_SUB) begin
      return S_INV;
    end else begin
      return S_PRIM;
    end
  endfunction

endpackage

// File: rtl/pmf_issue_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester strictly after ptr wins,
// wrapping modulo N. The pointer itself is held by the caller.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] winner
);

  logic found;
  int   idx;

  // Scan N positions starting at ptr+1 and keep the first ready one.
  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        winner     = IW'(idx);
        found      = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/pmf_issue_sched.sv
// Issue scheduler and sequencer for the shared pmfALU: round-robin issue from
// the reservation stations, ALU state sequencing and CDB request handshake.
module pmf_issue_sched
  import pmf_issue_sched_pkg::*;
#(
  parameter int NUM_RS  = 3,
  parameter int DATA_W  = 32,
  parameter int LABEL_W = 4
) (
  input  logic                      clk,
  input  logic                      RST,
  input  logic [NUM_RS-1:0]         rsReady,
  input  logic [2*NUM_RS-1:0]       rsOp,
  input  logic [DATA_W*NUM_RS-1:0]  rsData1,
  input  logic [DATA_W*NUM_RS-1:0]  rsData2,
  input  logic [LABEL_W*NUM_RS-1:0] rsLabel,
  output logic [NUM_RS-1:0]         rsGrant,
  output logic                      aluEN,
  output logic [1:0]                aluOp,
  output logic [DATA_W-1:0]         aluData1,
  output logic [DATA_W-1:0]         aluData2,
  output logic [LABEL_W-1:0]        aluLabel,
  output logic [1:0]                aluState,
  output logic                      cdbReq,
  output logic [LABEL_W-1:0]        cdbLabel,
  input  logic                      cdbAck,
  output logic                      busy,
  output logic [15:0]               issueCount
);

  localparam int PTR_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  sched_state_e       state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [LABEL_W-1:0] cdb_label_q, cdb_label_d;
  logic [15:0]        issue_count_q, issue_count_d;

  logic               cdb_req;
  logic               can_issue;
  logic               arb_en;
  logic               grant_any;
  logic [NUM_RS-1:0]  grant;
  logic [PTR_W-1:0]   winner;
  logic [1:0]         win_op;
  logic [DATA_W-1:0]  win_data1;
  logic [DATA_W-1:0]  win_data2;
  logic [LABEL_W-1:0] win_label;

  assign cdb_req   = (state_q == S_PRIM) || (state_q == S_MADD);
  assign can_issue = (state_q == S_IDLE) || (cdb_req && cdbAck);
  // No issue while in reset: the entry would be freed but its result discarded.
  assign arb_en    = can_issue && !RST;
  assign grant_any = |grant;

  rr_arbiter #(
    .N (NUM_RS)
  ) u_arb (
    .req    (rsReady),
    .ptr    (ptr_q),
    .en     (arb_en),
    .grant  (grant),
    .winner (winner)
  );

  // Select the winning entry's fields; zero them when nothing issues.
  always_comb begin
    win_op    = rsOp[int'(winner)*2 +: 2];
    win_data1 = rsData1[int'(winner)*DATA_W +: DATA_W];
    win_data2 = rsData2[int'(winner)*DATA_W +: DATA_W];
    win_label = rsLabel[int'(winner)*LABEL_W +: LABEL_W];
    if (grant_any) begin
      aluOp    = win_op;
      aluData1 = win_data1;
      aluData2 = win_data2;
      aluLabel = win_label;
    end else begin
      aluOp    = 2'b00;
      aluData1 = '0;
      aluData2 = '0;
      aluLabel = '0;
    end
  end

  // Sequencer next state plus pointer, tag and counter updates on issue.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cdb_label_d   = cdb_label_q;
    issue_count_d = issue_count_q;
    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          state_d = issue_state(win_op);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRIM, S_MADD: begin
        if (!cdbAck) begin
          state_d = state_q;
        end else if (grant_any) begin
          state_d = issue_state(win_op);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INV:   state_d = S_MADD;
      default: state_d = S_IDLE;
    endcase
    if (grant_any) begin
      ptr_d         = winner;
      cdb_label_d   = win_label;
      issue_count_d = issue_count_q + 16'd1;
    end else begin
      ptr_d         = ptr_q;
      cdb_label_d   = cdb_label_q;
      issue_count_d = issue_count_q;
    end
  end

  // State registers; reset overrides any grant or acknowledge.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q       <= S_IDLE;
      ptr_q         <= PTR_W'(NUM_RS - 1);
      cdb_label_q   <= '0;
      issue_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cdb_label_q   <= cdb_label_d;
      issue_count_q <= issue_count_d;
    end
  end

  assign rsGrant    = grant;
  assign aluEN      = grant_any;
  assign aluState   = state_q;
  assign cdbReq     = cdb_req;
  assign cdbLabel   = cdb_label_q;
  assign busy       = (state_q != S_IDLE);
  assign issueCount = issue_count_q;

endmodule

// File: tb/tb_pmf_issue_sched.sv
// Self-checking bench for pmf_issue_sched: directed scenarios plus randomized
// traffic checked against an in-flight-result model of the scheduler.
module tb_pmf_issue_sched;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;

  logic            clk = 1'b0;
  logic            RST;
  logic [N-1:0]    rsReady;
  logic [2*N-1:0]  rsOp;
  logic [DW*N-1:0] rsData1, rsData2;
  logic [LW*N-1:0] rsLabel;
  logic [N-1:0]    rsGrant;
  logic            aluEN;
  logic [1:0]      aluOp;
  logic [DW-1:0]   aluData1, aluData2;
  logic [LW-1:0]   aluLabel;
  logic [1:0]      aluState;
  logic            cdbReq;
  logic [LW-1:0]   cdbLabel;
  logic            cdbAck;
  logic            busy;
  logic [15:0]     issueCount;

  pmf_issue_sched #(.NUM_RS(N), .DATA_W(DW), .LABEL_W(LW)) dut (
    .clk(clk), .RST(RST), .rsReady(rsReady), .rsOp(rsOp),
    .rsData1(rsData1), .rsData2(rsData2), .rsLabel(rsLabel),
    .rsGrant(rsGrant), .aluEN(aluEN), .aluOp(aluOp),
    .aluData1(aluData1), .aluData2(aluData2), .aluLabel(aluLabel),
    .aluState(aluState), .cdbReq(cdbReq), .cdbLabel(cdbLabel),
    .cdbAck(cdbAck), .busy(busy), .issueCount(issueCount)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: one result in flight, "m_wait" cycles until it is valid on the CDB.
  bit          m_inflight;
  int          m_wait;
  bit          m_sub;
  logic [LW-1:0] m_label;
  int          m_ptr;
  logic [15:0] m_count;

  logic [N-1:0]  e_grant;
  int            e_win;
  logic          e_req;
  logic [1:0]    e_state;
  logic          e_busy;
  logic [1:0]    e_op;
  logic [DW-1:0] e_d1, e_d2;
  logic [LW-1:0] e_lbl;

  task automatic m_reset();
    m_inflight = 0; m_wait = 0; m_sub = 0; m_label = '0; m_ptr = N - 1; m_count = 16'd0;
  endtask

  task automatic predict();
    bit can;
    e_req = m_inflight && (m_wait == 0);
    can   = !m_inflight || (e_req && cdbAck);
    e_win = -1;
    if (can && !RST) begin
      for (int k = 1; k <= N; k++) begin
        if (e_win < 0 && rsReady[(m_ptr + k) % N]) e_win = (m_ptr + k) % N;
      end
    end
    e_grant = '0; e_op = 2'd0; e_d1 = '0; e_d2 = '0; e_lbl = '0;
    if (e_win >= 0) begin
      e_grant[e_win] = 1'b1;
      e_op  = rsOp[2*e_win +: 2];
      e_d1  = rsData1[DW*e_win +: DW];
      e_d2  = rsData2[DW*e_win +: DW];
      e_lbl = rsLabel[LW*e_win +: LW];
    end
    if (!m_inflight) e_state = 2'd0;
    else if (m_wait > 0) e_state = 2'd2;
    else e_state = m_sub ? 2'd3 : 2'd1;
    e_busy = m_inflight;
  endtask

  task automatic advance();
    if (RST) begin
      m_reset();
    end else if (e_win >= 0) begin
      m_inflight = 1; m_sub = (e_op == OP_SUB); m_wait = m_sub ? 1 : 0;
      m_label = e_lbl; m_ptr = e_win; m_count = m_count + 16'd1;
    end else if (e_req && cdbAck) begin
      m_inflight = 0;
    end else if (m_inflight && m_wait > 0) begin
      m_wait = m_wait - 1;
    end
  endtask

  task automatic settle();
    #1;
    predict();
  endtask

  task automatic tick();
    predict();
    @(posedge clk);
    advance();
    @(negedge clk);
  endtask

  task automatic set_entry(input int i, input logic [1:0] op, input logic [DW-1:0] d1,
                           input logic [DW-1:0] d2, input logic [LW-1:0] lbl);
    rsOp[2*i +: 2] = op; rsData1[DW*i +: DW] = d1; rsData2[DW*i +: DW] = d2; rsLabel[LW*i +: LW] = lbl;
  endtask

  task automatic test_reset();
    RST = 1'b1; rsReady = '1; cdbAck = 1'b1;
    tick(); tick();
    settle();
    n_cmp++; if (rsGrant !== 3'b000 || aluEN !== 1'b0) begin n_err++; $display("FAIL reset_grant: got %b/%b want 000/0", rsGrant, aluEN); end
    n_cmp++; if (aluState !== 2'd0 || cdbReq !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL reset_state: got st=%0d req=%b busy=%b want 0/0/0", aluState, cdbReq, busy); end
    n_cmp++; if (issueCount !== 16'd0 || cdbLabel !== 4'd0) begin n_err++; $display("FAIL reset_regs: got cnt=%0d lbl=%0d want 0/0", issueCount, cdbLabel); end
    RST = 1'b0; rsReady = '0; cdbAck = 1'b0;
  endtask

  task automatic test_add();
    set_entry(0, OP_ADD, 32'd5, 32'd7, 4'd3);
    rsReady = 3'b001;
    settle();
    n_cmp++; if (rsGrant !== 3'b001 || aluEN !== 1'b1) begin n_err++; $display("FAIL add_grant: got %b/%b want 001/1", rsGrant, aluEN); end
    n_cmp++; if (aluOp !== OP_ADD || aluData1 !== 32'd5 || aluData2 !== 32'd7 || aluLabel !== 4'd3) begin n_err++; $display("FAIL add_operands: got op=%0d %0d,%0d tag %0d want 0 5,7 tag 3", aluOp, aluData1, aluData2, aluLabel); end
    tick(); rsReady = 3'b000;
    settle();
    n_cmp++; if (aluState !== 2'd1 || cdbReq !== 1'b1 || cdbLabel !== 4'd3) begin n_err++; $display("FAIL add_result: got st=%0d req=%b lbl=%0d want 1/1/3", aluState, cdbReq, cdbLabel); end
    cdbAck = 1'b1; tick(); cdbAck = 1'b0;
    settle();
    n_cmp++; if (aluState !== 2'd0 || cdbReq !== 1'b0 || issueCount !== 16'd1) begin n_err++; $display("FAIL add_retire: got st=%0d req=%b cnt=%0d want 0/0/1", aluState, cdbReq, issueCount); end
  endtask

  task automatic test_sub();
    set_entry(1, OP_SUB, 32'd10, 32'd3, 4'd5);
    rsReady = 3'b010; cdbAck = 1'b1;
    settle();
    n_cmp++; if (rsGrant !== 3'b010 || aluOp !== OP_SUB) begin n_err++; $display("FAIL sub_grant: got %b op=%0d want 010 op=1", rsGrant, aluOp); end
    tick(); rsReady = 3'b000;
    settle();
    n_cmp++; if (aluState !== 2'd2 || cdbReq !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL sub_inv: got st=%0d req=%b busy=%b want 2/0/1", aluState, cdbReq, busy); end
    tick();
    settle();
    n_cmp++; if (aluState !== 2'd3 || cdbReq !== 1'b1 || cdbLabel !== 4'd5) begin n_err++; $display("FAIL sub_madd: got st=%0d req=%b lbl=%0d want 3/1/5", aluState, cdbReq, cdbLabel); end
    tick(); cdbAck = 1'b0;
    settle();
    n_cmp++; if (aluState !== 2'd0 || issueCount !== m_count) begin n_err++; $display("FAIL sub_retire: got st=%0d cnt=%0d want 0/%0d", aluState, issueCount, m_count); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] want;
    RST = 1'b1; tick(); RST = 1'b0;
    for (int i = 0; i < N; i++) set_entry(i, OP_ADD, DW'(i + 100), DW'(i + 200), LW'(i + 1));
    rsReady = 3'b111; cdbAck = 1'b1;
    for (int c = 0; c < 6; c++) begin
      settle();
      want = 3'b001 << (c % 3);
      n_cmp++; if (rsGrant !== want) begin n_err++; $display("FAIL b2b_grant: cycle %0d got %b want %b", c, rsGrant, want); end
      if (c > 0) begin
        n_cmp++; if (cdbReq !== 1'b1 || aluState !== 2'd1) begin n_err++; $display("FAIL b2b_req: cycle %0d got req=%b st=%0d want 1/1", c, cdbReq, aluState); end
      end
      tick();
    end
    rsReady = 3'b000; cdbAck = 1'b0;
  endtask

  task automatic test_ack_hold();
    logic [LW-1:0] held;
    settle();
    held = cdbLabel;
    set_entry(2, OP_ADD, 32'd9, 32'd1, 4'd9);
    rsReady = 3'b100; cdbAck = 1'b0;
    for (int c = 0; c < 5; c++) begin
      settle();
      n_cmp++; if (rsGrant !== 3'b000 || cdbReq !== 1'b1 || cdbLabel !== held || cdbLabel !== m_label) begin n_err++; $display("FAIL hold_stable: cycle %0d got g=%b req=%b lbl=%0d want 000/1/%0d", c, rsGrant, cdbReq, cdbLabel, m_label); end
      tick();
    end
    cdbAck = 1'b1;
    settle();
    n_cmp++; if (rsGrant !== 3'b100) begin n_err++; $display("FAIL hold_ack_grant: got %b want 100", rsGrant); end
    tick(); cdbAck = 1'b0; rsReady = 3'b000;
    settle();
    n_cmp++; if (cdbReq !== 1'b1 || cdbLabel !== 4'd9) begin n_err++; $display("FAIL hold_new_result: got req=%b lbl=%0d want 1/9", cdbReq, cdbLabel); end
    cdbAck = 1'b1; tick(); cdbAck = 1'b0;
  endtask

  task automatic test_reset_inv();
    set_entry(1, OP_SUB, 32'd4, 32'd2, 4'd7);
    rsReady = 3'b010;
    tick(); rsReady = 3'b111;
    settle();
    n_cmp++; if (aluState !== 2'd2) begin n_err++; $display("FAIL rinv_inv: got st=%0d want 2", aluState); end
    RST = 1'b1;
    settle();
    n_cmp++; if (rsGrant !== 3'b000) begin n_err++; $display("FAIL rinv_nogrant: got %b want 000", rsGrant); end
    tick(); RST = 1'b0;
    settle();
    n_cmp++; if (aluState !== 2'd0 || cdbReq !== 1'b0 || issueCount !== 16'd0) begin n_err++; $display("FAIL rinv_cleared: got st=%0d req=%b cnt=%0d want 0/0/0", aluState, cdbReq, issueCount); end
    n_cmp++; if (rsGrant !== 3'b001) begin n_err++; $display("FAIL rinv_priority: got %b want 001", rsGrant); end
    tick(); rsReady = 3'b000; cdbAck = 1'b1; tick(); cdbAck = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rsReady = N'($urandom);
      rsOp    = (2*N)'($urandom);
      for (int i = 0; i < N; i++) begin
        rsData1[DW*i +: DW] = $urandom; rsData2[DW*i +: DW] = $urandom; rsLabel[LW*i +: LW] = LW'($urandom);
      end
      cdbAck = 1'($urandom_range(0, 1));
      RST    = ($urandom_range(0, 39) == 0);
      settle();
      n_cmp++; if (rsGrant !== e_grant || aluEN !== (|e_grant) || aluOp !== e_op || aluData1 !== e_d1 || aluData2 !== e_d2 || aluLabel !== e_lbl) begin
        n_err++; $display("FAIL rand_issue: cycle %0d got g=%b op=%0d lbl=%0d want g=%b op=%0d lbl=%0d", c, rsGrant, aluOp, aluLabel, e_grant, e_op, e_lbl); end
      n_cmp++; if (aluState !== e_state || cdbReq !== e_req || busy !== e_busy || cdbLabel !== m_label || issueCount !== m_count) begin
        n_err++; $display("FAIL rand_state: cycle %0d got st=%0d req=%b busy=%b lbl=%0d cnt=%0d want %0d/%b/%b/%0d/%0d", c, aluState, cdbReq, busy, cdbLabel, issueCount, e_state, e_req, e_busy, m_label, m_count); end
      tick();
    end
    RST = 1'b0; rsReady = '0; cdbAck = 1'b0;
  endtask

  task automatic test_count_wrap();
    RST = 1'b1; tick(); RST = 1'b0;
    rsOp = '0; rsReady = 3'b111; cdbAck = 1'b1;
    for (int c = 0; c < 65535; c++) tick();
    settle();
    n_cmp++; if (issueCount !== 16'hFFFF || issueCount !== m_count) begin n_err++; $display("FAIL wrap_preset: got %h want ffff", issueCount); end
    n_cmp++; if (rsGrant !== e_grant || aluEN !== 1'b1) begin n_err++; $display("FAIL wrap_grant: got %b want %b", rsGrant, e_grant); end
    tick();
    settle();
    n_cmp++; if (issueCount !== 16'h0000) begin n_err++; $display("FAIL wrap_zero: got %h want 0000", issueCount); end
    rsReady = '0; cdbAck = 1'b0;
  endtask

  initial begin
    RST = 1'b1; rsReady = '0; rsOp = '0; rsData1 = '0; rsData2 = '0; rsLabel = '0; cdbAck = 1'b0;
    m_reset();
    @(negedge clk);
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_ack_hold();
    test_reset_inv();
    test_random();
    test_count_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pmf_issue_sched.md
# pmf_issue_sched

Issue scheduler and sequencer for the shared plus/minus/logic execution unit (`pmfALU`). It arbitrates round-robin among `NUM_RS` reservation-station entries whose operands are ready. It forwards the winner's operands, op and label to the ALU and drives the ALU's `state` input. It then holds the result on the common data bus (CDB) request until acknowledged, and it replaces the standalone `pmfState` controller.

## Interface
- `NUM_RS`, 3, number of reservation-station entries served (2..8)
- `DATA_W`, 32, operand width
- `LABEL_W`, 4, tag width
- `clk`  in  1  clock, all state updates on rising edge
- `RST`  in  1  synchronous, active-high reset
- `rsReady`  in  NUM_RS  entry i holds both operands and waits to issue
- `rsOp`  in  2*NUM_RS  op of entry i in bits [2i+1:2i], `ALU*` encoding
- `rsData1`, `rsData2`  in  DATA_W*NUM_RS  operands of entry i, flattened, entry 0 in LSBs
- `rsLabel`  in  LABEL_W*NUM_RS  destination tag of entry i
- `rsGrant`  out  NUM_RS  one-hot, combinational; entry issued this cycle; the RS frees the entry on this edge
- `aluEN`  out  1  ALU latch enable; equals |rsGrant
- `aluOp`  out  2  op of granted entry; 0 when no grant
- `aluData1`, `aluData2`  out  DATA_W  granted operands; 0 when no grant
- `aluLabel`  out  LABEL_W  granted tag; 0 when no grant
- `aluState`  out  2  current sequencer state, wired to the ALU `state` input
- `cdbReq`  out  1  ALU result valid, requesting the CDB
- `cdbLabel`  out  LABEL_W  tag of the in-flight result
- `cdbAck`  in  1  CDB grant; meaningful only while `cdbReq`=1
- `busy`  out  1  state ≠ IDLE
- `issueCount`  out  16  issued-instruction counter, wraps modulo 2^16

## Operation
- States use the shared encoding: IDLE=0, PRIM=1 (single-pass result valid), INV=2 (subtract, negating operand 2), MADD=3 (subtract result valid).
- `cdbReq` = (state==PRIM || state==MADD).
- `canIssue` = (state==IDLE) || (cdbReq && cdbAck).
- Arbitration:
  - If `canIssue` and any `rsReady`, grant the first ready entry searching from `ptr+1` upward, wrapping modulo NUM_RS.
  - On a grant, `ptr` ← winner.
  - Non-ready entries are never granted; withdrawing `rsReady` without a grant has no effect.
- Transitions:
  - IDLE: grant → (op==`ALUSub` ? INV : PRIM); no grant → IDLE.
  - PRIM/MADD: `cdbAck`=0 → hold, with `cdbReq` and `cdbLabel` stable. `cdbAck`=1 → grant ? (op==`ALUSub` ? INV : PRIM) : IDLE.
  - INV: unconditionally → MADD; no grant is issued from INV.
- `cdbLabel` register loads the granted `rsLabel` on every grant edge.
- `issueCount` increments on every grant edge.
- Reset values: state=IDLE, `ptr`=NUM_RS-1 (entry 0 has first priority), `cdbLabel`=0, `issueCount`=0. All combinational outputs are therefore 0 except those following `rsReady`. Reset has priority over grant and ack.

## Timing
- Non-subtract op issued at edge N (`rsGrant`/`aluEN` high in cycle N-1→N): `cdbReq`=1 from cycle N. Issue-to-request latency is 1.
- Subtract issued at edge N: INV during cycle N, MADD/`cdbReq` from cycle N+1. Latency is 2.
- Back-to-back: when `cdbAck` and a ready entry coincide, the new instruction issues on the same edge the old result retires. There is no bubble, and `cdbReq` stays 1.
- Reset asserted mid-operation (any state): next edge forces IDLE, and `cdbReq` is 0 from the following cycle. An in-flight result is discarded, and no grant is issued in a reset cycle (`rsGrant` forced 0 while `RST`=1).
- `cdbAck` with `cdbReq`=0 is ignored.

## Structure
- State codes, `ALUAdd`/`ALUSub`/`ALUAnd`/`ALUOr` op codes and the state encoding live in the shared `head.v` header. The existing `sIdle`/`sPremitiveIns`/`sInverse`/`sMAdd` macros are reused, so `aluState` matches the ALU's expectation.
- One sub-module: `rr_arbiter` (parameter N; inputs `req`, `ptr`, `en`; outputs `grant` one-hot and `winner` index). It is purely combinational; `ptr` is held in `pmf_issue_sched`.
- Operand and label muxing is done in `pmf_issue_sched` from `winner`.

## Test plan
- Reset, then `rsReady`=001, entry 0 ADD 5,7 tag 3:
  - `rsGrant`=001 in the same cycle, `aluEN`=1.
  - Next cycle `aluState`=PRIM, `cdbReq`=1, `cdbLabel`=3.
  - `cdbAck` → IDLE, `issueCount`=1.
- Entry 1 SUB 10,3 tag 5, `cdbAck` tied 1:
  - States go INV then MADD.
  - `cdbReq` rises 2 cycles after the grant, with `cdbLabel`=5.
- All three entries ready continuously, `cdbAck`=1 every cycle, all ADD:
  - Grants follow 001,010,100,001 on consecutive cycles.
  - `cdbReq` stays high throughout.
- `cdbAck` held 0 for 5 cycles with entry 2 ready:
  - `rsGrant` stays 0, and `cdbReq`/`cdbLabel` are stable.
  - Grant to entry 2 occurs only on the `cdbAck` cycle.
- `RST` pulsed during INV: next cycle IDLE, `cdbReq`=0, `issueCount`=0, and the entry-0-first priority is restored.
- `issueCount` preset near 0xFFFF via 65535 issues: wraps to 0 on the next grant.
